seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_pkg.sv | 15 +
 rtl/seg_decode.sv | 11 +
 rtl/seg_scan_mux.sv | 151 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: blank pattern and
// active-low hex glyphs, segment order a..g with a in bit 0 of a [0:6] vector.
package seg_scan_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    // b and d are the lowercase forms so they stay distinct from 8 and 0
    localparam logic [0:6] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [0:6] o_seg
);

    assign o_seg = GLYPH[i_nib];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display driver: prescaled digit scan, tear-free
// shadow/active data update at frame wrap, blanking, blink and zero suppression.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 100000,
    parameter int BLINK_DIV = 64
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] digits,
    input  logic              load,
    input  logic [NDIG-1:0]   blank,
    input  logic [NDIG-1:0]   blink,
    input  logic [NDIG-1:0]   dp,
    input  logic              lz_en,
    output logic [NDIG-1:0]   an,
    output logic [0:6]        seg,
    output logic              dp_n,
    output logic              frame_done
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0]     r_pre;
    logic [IW-1:0]     r_idx;
    logic [BW-1:0]     r_bcnt;
    logic              r_phase;
    logic              r_pend;
    logic [4*NDIG-1:0] r_sh_dig,   r_ac_dig;
    logic [NDIG-1:0]   r_sh_blank, r_ac_blank;
    logic [NDIG-1:0]   r_sh_blink, r_ac_blink;
    logic [NDIG-1:0]   r_sh_dp,    r_ac_dp;
    logic [NDIG-1:0]   r_an;
    logic [0:6]        r_seg;
    logic              r_dp_n;
    logic              r_fd;

    logic              w_tick;
    logic              w_wrap;
    logic [3:0]        w_nib;
    logic [0:6]        w_glyph;
    logic [NDIG-1:0]   w_zero_up;
    logic              w_sup;
    logic              w_dark;

    assign w_tick = (r_pre == PRE_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            if (w_wrap) begin
                if (r_bcnt == BLK_LAST) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt  <= r_bcnt + BW'(1);
                end
            end
        end
    end

    // Commit takes the shadow as it stood before this edge; a load landing on
    // the wrap edge stays pending for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_sh_dig   <= '0;
            r_sh_blank <= '0;
            r_sh_blink <= '0;
            r_sh_dp    <= '0;
            r_ac_dig   <= '0;
            r_ac_blank <= '0;
            r_ac_blink <= '0;
            r_ac_dp    <= '0;
        end else begin
            if (w_wrap && r_pend) begin
                r_ac_dig   <= r_sh_dig;
                r_ac_blank <= r_sh_blank;
                r_ac_blink <= r_sh_blink;
                r_ac_dp    <= r_sh_dp;
            end
            if (load) begin
                r_sh_dig   <= digits;
                r_sh_blank <= blank;
                r_sh_blink <= blink;
                r_sh_dp    <= dp;
                r_pend     <= 1'b1;
            end else if (w_wrap) begin
                r_pend     <= 1'b0;
            end
        end
    end

    // w_zero_up[i]: nibbles i..NDIG-1 of the active data are all zero
    always_comb begin
        w_zero_up = '0;
        for (int i = 0; i < NDIG; i++)
            w_zero_up[i] = ((r_ac_dig >> (4 * i)) == '0);
    end

    assign w_nib  = r_ac_dig[{r_idx, 2'b00} +: 4];
    assign w_sup  = lz_en && (r_idx != '0) && w_zero_up[r_idx];
    assign w_dark = r_ac_blank[r_idx] || (r_ac_blink[r_idx] && r_phase) || w_sup;

    seg_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an   <= '1;
            r_seg  <= SEG_OFF;
            r_dp_n <= 1'b1;
            r_fd   <= 1'b0;
        end else begin
            r_fd <= w_wrap;
            if (w_dark) begin
                r_an   <= '1;
                r_seg  <= SEG_OFF;
                r_dp_n <= 1'b1;
            end else begin
                r_an   <= ~(NDIG'(1) << r_idx);
                r_seg  <= w_glyph;
                r_dp_n <= ~r_ac_dp[r_idx];
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux at NDIG=4, DIV=4, BLINK_DIV=2: one frame is 16 clk.
module tb_seg_scan_mux;

    localparam int NDIG = 4, DIV = 4, BLINK_DIV = 2;

    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G6 = 7'b0100000, G7 = 7'b0001111;
    localparam logic [6:0] G9 = 7'b0000100, GA = 7'b0001000, Gb = 7'b1100000, GC = 7'b0110001;
    localparam logic [6:0] Gd = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;
    localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AX = 4'b1111;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      blank;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][3:0] an;   // {slot3, slot2, slot1, slot0}
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic        load;
    logic [3:0]  blank, blink, dp;
    logic        lz_en;
    logic [3:0]  an;
    logic [0:6]  seg;
    logic        dp_n, frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_fd;

    seg_scan_mux #(.NDIG(NDIG), .DIV(DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .load       (load),
        .blank      (blank),
        .blink      (blink),
        .dp         (dp),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // frame wraps seen since reset; bumps on the edge after each pulse
    always @(posedge clk or posedge reset)
        if (reset) n_fd <= 0;
        else if (frame_done) n_fd <= n_fd + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge where frame_done is high; samples mid-slot of each
    // digit of the frame just started and returns at the next frame_done negedge.
    task automatic capture_frame(input bit do_load, input logic [15:0] d, input logic [3:0] bl,
                                 input logic [3:0] bk, input logic [3:0] p, input logic lz,
                                 output logic [3:0][3:0] ca, output logic [3:0][6:0] cs,
                                 output logic [3:0] cd);
        if (do_load) begin
            digits = d; blank = bl; blink = bk; dp = p; load = 1'b1;
        end
        lz_en = lz;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            ca[k] = an;
            cs[k] = seg;
            cd[k] = dp_n;
            chk($sformatf("one_an_low slot%0d", k), ($countones(~an) <= 1), 1);
            chk($sformatf("fd_low slot%0d", k), frame_done, 0);
            if (k < 3) repeat (4) @(negedge clk);
            else       repeat (2) @(negedge clk);
        end
        chk("fd_pulse_at_frame_end", frame_done, 1);
    endtask

    task automatic cmp_frame(input string tag, input vec_t v, input logic [3:0][3:0] ca,
                             input logic [3:0][6:0] cs, input logic [3:0] cd);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s an slot%0d", tag, k), ca[k], v.an[k]);
            chk($sformatf("%s seg slot%0d", tag, k), cs[k], v.seg[k]);
            chk($sformatf("%s dp_n slot%0d", tag, k), cd[k], v.dpn[k]);
        end
    endtask

    // Entered at the negedge of reset release; follows one full frame of zeros.
    task automatic scan_from_release(input string tag);
        logic [3:0] slot_an [4];
        int cyc;
        slot_an = '{A0, A1, A2, A3};
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if ((cyc % 4) == 2 && cyc < 16) begin
                chk($sformatf("%s an cyc%0d", tag, cyc), an, slot_an[cyc / 4]);
                chk($sformatf("%s seg cyc%0d", tag, cyc), seg, G0);
            end
        end while (!frame_done && cyc < 40);
        chk($sformatf("%s first_fd_cycle", tag), cyc, 16);
    endtask

    vec_t vt [8];
    vec_t zv, v1111, v2222, vb;
    logic [3:0][3:0] ca;
    logic [3:0][6:0] cs;
    logic [3:0]      cd;

    initial begin
        vt[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {A3, A2, A1, A0}, {G1, G2, GA, GF}, 4'b1111};
        vt[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {AX, AX, A1, A0}, {OFF, OFF, G5, G0}, 4'b1111};
        vt[2] = '{16'h0050, 4'b0000, 4'b0000, 1'b0, {A3, A2, A1, A0}, {G0, G0, G5, G0}, 4'b1111};
        vt[3] = '{16'hC83E, 4'b0100, 4'b0101, 1'b0, {A3, AX, A1, A0}, {GC, OFF, G3, GE}, 4'b1110};
        vt[4] = '{16'h0007, 4'b0000, 4'b1000, 1'b1, {AX, AX, AX, A0}, {OFF, OFF, OFF, G7}, 4'b1111};
        vt[5] = '{16'h0000, 4'b0000, 4'b0001, 1'b1, {AX, AX, AX, A0}, {OFF, OFF, OFF, G0}, 4'b1110};
        vt[6] = '{16'h9B6D, 4'b0000, 4'b1111, 1'b1, {A3, A2, A1, A0}, {G9, Gb, G6, Gd}, 4'b0000};
        vt[7] = '{16'h0400, 4'b0000, 4'b0000, 1'b1, {AX, A2, A1, A0}, {OFF, G4, G0, G0}, 4'b1111};
        zv    = '{16'h0000, 4'b0000, 4'b0000, 1'b0, {A3, A2, A1, A0}, {G0, G0, G0, G0}, 4'b1111};
        v1111 = '{16'h1111, 4'b0000, 4'b0000, 1'b0, {A3, A2, A1, A0}, {G1, G1, G1, G1}, 4'b1111};
        v2222 = '{16'h2222, 4'b0000, 4'b0000, 1'b0, {A3, A2, A1, A0}, {G2, G2, G2, G2}, 4'b1111};

        reset = 1'b1; load = 1'b0; digits = '0; blank = '0; blink = '0; dp = '0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset an", an, 4'b1111);
        chk("reset seg", seg, OFF);
        chk("reset dp_n", dp_n, 1);
        chk("reset frame_done", frame_done, 0);
        reset = 1'b0;
        scan_from_release("startup");

        // table: the first row also confirms the old frame is untouched by a mid-frame load
        for (int i = 0; i < 8; i++) begin
            capture_frame(1'b1, vt[i].digits, vt[i].blank, 4'b0000, vt[i].dp, vt[i].lz, ca, cs, cd);
            if (i == 0) cmp_frame("pre_commit", zv, ca, cs, cd);
            capture_frame(1'b0, '0, '0, '0, '0, vt[i].lz, ca, cs, cd);
            cmp_frame($sformatf("vec%0d", i), vt[i], ca, cs, cd);
        end

        // load on the wrap edge while another load is pending
        digits = 16'h1111; blank = '0; blink = '0; dp = '0; lz_en = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (14) @(negedge clk);
        digits = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("wrap_load fd", frame_done, 1);
        capture_frame(1'b0, '0, '0, '0, '0, 1'b0, ca, cs, cd);
        cmp_frame("wrap_load first", v1111, ca, cs, cd);
        capture_frame(1'b0, '0, '0, '0, '0, 1'b0, ca, cs, cd);
        cmp_frame("wrap_load second", v2222, ca, cs, cd);

        // blink on digit 0: phase after wrap n is (n/2)%2, dark while 1
        capture_frame(1'b1, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, ca, cs, cd);
        for (int f = 0; f < 4; f++) begin
            int n;
            n  = n_fd + 1;
            vb = zv;
            if (((n / 2) % 2) == 1) begin
                vb.an[0]  = AX;
                vb.seg[0] = OFF;
            end
            capture_frame(1'b0, '0, '0, '0, '0, 1'b0, ca, cs, cd);
            cmp_frame($sformatf("blink frame%0d wrap%0d", f, n), vb, ca, cs, cd);
        end

        // reset mid-slot with a pending load
        digits = 16'h3333; blink = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset an", an, 4'b1111);
        chk("async_reset seg", seg, OFF);
        chk("async_reset dp_n", dp_n, 1);
        chk("async_reset frame_done", frame_done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        scan_from_release("after_reset");
        capture_frame(1'b0, '0, '0, '0, '0, 1'b0, ca, cs, cd);
        cmp_frame("after_reset frame", zv, ca, cs, cd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
